uart_rx: RTL
============

Name: uart_rx

Overview:
Serial UART receiver. It consumes the 8-bit serial frame format produced by the team's UART transmitter: start bit, 8 data bits LSB first, optional parity bit, then stop bit(s). It recovers the byte, checks parity and framing, and presents the byte with a one-cycle valid strobe to the downstream logic. The bit timing is the same as the codebase's UART, so the receiver pairs directly with the transmitter line.

Parameters:
p_clk_speed_hz, 50_000_000, system clock frequency in Hz
p_baud_rate, 9_600, line baud rate
Derived, not overridable: CYCLES_PER_BIT = p_clk_speed_hz / p_baud_rate (integer division); HALF = CYCLES_PER_BIT / 2; counter width = $clog2(CYCLES_PER_BIT) + 1

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  reset, asynchronous, active-low
enable_i  input  1  allows leaving IDLE on a start edge
data_i  input  1  serial line, asynchronous to clk_i, idle high
parity_en_i  input  1  1 = frame carries a parity bit
parity_sel_i  input  1  expected parity bit = parity_sel_i ? ^byte : ~^byte
data_o  output  8  last received byte
valid_o  output  1  one-cycle strobe, new byte on data_o
parity_err_o  output  1  parity mismatch for the byte strobed with valid_o
frame_err_o  output  1  stop bit sampled low for the byte strobed with valid_o
busy_o  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. All state is cleared immediately on rst_n_i low, with no clock edge required.
- Reset values:
  - data_o = 0, valid_o = 0, parity_err_o = 0, frame_err_o = 0, busy_o = 0.
  - Synchroniser flops = 1, state = IDLE, bit counter = 0, armed = 1.
- Input synchronisation:
  - data_i passes through a 2-flop synchroniser. Only the synchronised value (rx_s) is used.
  - This adds 2 clocks of latency, which are included in all timings below.
- Bit period: CYCLES_PER_BIT+1 clocks. The cycle counter runs 0..CYCLES_PER_BIT inclusive and is reset to 0 at every sample point.
- State machine (IDLE, START, DATA, PARITY, STOP):
  - IDLE:
    - Cycle counter is held at 0.
    - armed is set when rx_s == 1.
    - If enable_i && armed && rx_s == 0, go to START.
  - START:
    - Sample at counter == HALF.
    - rx_s == 0: reset counter, go to DATA with bit index 0.
    - rx_s == 1: false start; return to IDLE with no strobe and no error.
  - DATA:
    - Sample at counter == CYCLES_PER_BIT and shift the sample into bit[index].
    - After index 7 is sampled: go to PARITY if parity_en_i, else STOP.
    - parity_en_i is sampled at that transition.
  - PARITY:
    - Sample at counter == CYCLES_PER_BIT.
    - Latch mismatch = sampled bit != expected parity, using parity_sel_i at that cycle.
    - Go to STOP.
  - STOP:
    - Sample at counter == CYCLES_PER_BIT.
    - Update data_o, frame_err_o = ~rx_s, and parity_err_o (0 when parity is disabled).
    - Go to IDLE.
    - On frame error, clear armed.
- Output strobe:
  - valid_o is high for exactly the one clock after the stop sample.
  - data_o and the error flags hold their values until the next stop sample.
  - The error flags are meaningful only while valid_o is high.
- Stop bits: only the first stop bit is checked. Extra stop bits are treated as idle. Returning to IDLE at mid-stop allows back-to-back frames with a single stop bit.
- enable_i gates only the IDLE→START transition. Dropping it mid-frame does not abort the frame.
- Break or stuck-low line: after a frame error, no new frame starts until rx_s has been seen high for at least 1 clock.
- Async reset mid-frame: the frame is discarded and no strobe is produced.
- Sample-point latency: with the line falling at clock edge N, the start sample happens at edge N+2+1+HALF (±1 for synchroniser alignment). Each following sample is +CYCLES_PER_BIT+1 clocks after the previous one.

Test Plan:
Bench parameters for all tests: p_clk_speed_hz=1_000_000, p_baud_rate=100_000, so CYCLES_PER_BIT=10, bit period = 11 clocks, HALF=5.
1. Send 0xA5, parity off, 1 stop bit → exactly one valid_o pulse; data_o=0xA5; parity_err_o=0; frame_err_o=0; busy_o returns to 0.
2. parity_en_i=1, parity_sel_i=1, send 0x03 with parity bit 0 → parity_err_o=0. Resend with parity bit 1 → valid_o pulse, data_o=0x03, parity_err_o=1.
3. Send 0x55 with stop bit low, then hold the line low 30 clocks, then release high → valid_o pulse with frame_err_o=1; no further valid_o while the line is low. A clean 0x11 sent afterwards is received correctly.
4. Line low glitch of 3 clocks → busy_o pulses high, returns to IDLE, no valid_o.
5. Back-to-back frames 0x00 then 0xFF, single stop bit, no idle gap → two valid_o pulses 110 clocks apart; data_o=0x00, then 0xFF.
6. Assert rst_n_i low between clock edges during data bit 4 → all outputs at reset values immediately. After release, a clean 0x3C frame is received with no spurious strobe.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, 8 data bits LSB first, optional parity, one stop bit checked.
// Presents each received byte with a one-clock valid strobe plus parity/framing error flags.
module uart_rx #(
  parameter int p_clk_speed_hz = 50_000_000,
  parameter int p_baud_rate    = 9_600
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       enable_i,
  input  logic       data_i,
  input  logic       parity_en_i,
  input  logic       parity_sel_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       busy_o
);
  localparam int CPB  = p_clk_speed_hz / p_baud_rate;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(CPB);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          r_state;
  logic            r_sync1, r_sync2;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic            r_par_en, r_par_err, r_armed;
  logic            w_rx;

  assign w_rx   = r_sync2;
  assign busy_o = (r_state != IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_par_en     <= 1'b0;
      r_par_err    <= 1'b0;
      r_armed      <= 1'b1;
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      r_sync1 <= data_i;
      r_sync2 <= r_sync1;
      valid_o <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_rx) r_armed <= 1'b1;
          if (enable_i && r_armed && !w_rx) r_state <= START;
        end
        START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt <= '0;
            r_idx <= '0;
            // A start bit that is gone by mid-bit was a glitch: drop it silently.
            r_state <= w_rx ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DATA: begin
          if (r_cnt == CNT_FULL) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= w_rx;
            if (r_idx == 3'd7) begin
              r_par_en <= parity_en_i;
              r_state  <= parity_en_i ? PARITY : STOP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        PARITY: begin
          if (r_cnt == CNT_FULL) begin
            r_cnt     <= '0;
            r_par_err <= w_rx != (parity_sel_i ? ^r_shift : ~^r_shift);
            r_state   <= STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        STOP: begin
          if (r_cnt == CNT_FULL) begin
            r_cnt        <= '0;
            data_o       <= r_shift;
            frame_err_o  <= ~w_rx;
            parity_err_o <= r_par_en & r_par_err;
            valid_o      <= 1'b1;
            // A low stop bit may be a break; wait for the line to go high before rearming.
            if (!w_rx) r_armed <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
